// File: rtl/sync_calc_pkg.sv
// Shared definitions for the sequential power unit: FSM states, mode codes and
// the accumulator width rule.
package sync_calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_CUBE   = 1'b1;

  // A cube of an n-bit operand needs 3n bits.
  function automatic int unsigned acc_width(input int unsigned data_bits);
    return 3 * data_bits;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per step, reloadable so a
// single instance serves both the square and the cube pass.
module seq_shift_add_mul
  import sync_calc_pkg::*;
#(
  parameter int unsigned data_bits = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic                                step,
  input  logic [acc_width(data_bits)-1:0]     mcand,
  input  logic [data_bits-1:0]                mplier,
  output logic [acc_width(data_bits)-1:0]     acc_next_c,
  output logic                                last_c
);

  localparam int unsigned ACC_W = acc_width(data_bits);
  localparam int unsigned CNT_W = $clog2(data_bits);

  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority so the top can chain the second pass on the last step.
  always_comb begin
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_next_c = mplier[cnt_q] ? acc_q + (mcand_q << cnt_q) : acc_q;
    last_c     = (cnt_q == CNT_W'(data_bits - 1));
    if (load) begin
      mcand_d = mcand;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (step) begin
      acc_d = acc_next_c;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_power_calc.sv
// Sequential square/cube unit: captures Din on Start, runs one or two
// shift-add passes, then presents a saturated result with an overflow flag.
module sync_power_calc
  import sync_calc_pkg::*;
#(
  parameter int unsigned data_bits = 6,
  parameter int unsigned OUT_BITS  = 6
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Mode,
  input  logic [data_bits-1:0] Din,
  output logic [OUT_BITS-1:0]  Dout,
  output logic                 Ready,
  output logic                 Error,
  output logic                 Busy
);

  localparam int unsigned ACC_W = acc_width(data_bits);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [data_bits-1:0]  a_q, a_d;
  logic [OUT_BITS-1:0]   dout_q, dout_d;
  logic                  error_q, error_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic                  mul_load_c, mul_step_c, mul_last_c, ovf_c;
  logic [ACC_W-1:0]      mul_mcand_c, mul_acc_next_c;

  seq_shift_add_mul #(.data_bits(data_bits)) u_mul (
    .clk        (Clk),
    .reset      (Reset),
    .load       (mul_load_c),
    .step       (mul_step_c),
    .mcand      (mul_mcand_c),
    .mplier     (a_q),
    .acc_next_c (mul_acc_next_c),
    .last_c     (mul_last_c)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    a_d         = a_q;
    dout_d      = dout_q;
    error_d     = error_q;
    mul_load_c  = 1'b0;
    mul_step_c  = 1'b0;
    mul_mcand_c = '0;
    // Overflow judged on the full-width result, before any truncation.
    ovf_c       = |(mul_acc_next_c >> OUT_BITS);

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d     = MUL1;
          mode_d      = Mode;
          a_d         = Din;
          dout_d      = '0;
          error_d     = 1'b0;
          mul_load_c  = 1'b1;
          mul_mcand_c = ACC_W'(Din);
        end
      end
      MUL1: begin
        mul_step_c = 1'b1;
        if (mul_last_c) begin
          if (mode_q == MODE_CUBE) begin
            state_d     = MUL2;
            mul_load_c  = 1'b1;
            mul_mcand_c = mul_acc_next_c;
          end else begin
            state_d = DONE;
            dout_d  = ovf_c ? '1 : mul_acc_next_c[OUT_BITS-1:0];
            error_d = ovf_c;
          end
        end
      end
      MUL2: begin
        mul_step_c = 1'b1;
        if (mul_last_c) begin
          state_d = DONE;
          dout_d  = ovf_c ? '1 : mul_acc_next_c[OUT_BITS-1:0];
          error_d = ovf_c;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == DONE);
    busy_d  = (state_d == MUL1) || (state_d == MUL2);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_SQUARE;
      a_q     <= '0;
      dout_q  <= '0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      error_q <= error_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign Dout  = dout_q;
  assign Error = error_q;
  assign Ready = ready_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_sync_power_calc.sv
// Scoreboard bench for sync_power_calc: the driver queues expected results from a
// plain-arithmetic model, a monitor checks them whenever Ready rises.
module tb_sync_power_calc;

  localparam int unsigned DB = 6;
  localparam int unsigned OB = 6;

  typedef struct {
    logic [OB-1:0] dout;
    logic          err;
    int            cap;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [DB-1:0] din;
  logic [OB-1:0] dout;
  logic          ready, error, busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  logic prev_ready = 1'b0;

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_power_calc #(.data_bits(DB), .OUT_BITS(OB)) dut (
    .Clk   (clk),
    .Reset (reset),
    .Start (start),
    .Mode  (mode),
    .Din   (din),
    .Dout  (dout),
    .Ready (ready),
    .Error (error),
    .Busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit m, input int d, input int cap);
    exp_t        e;
    longint      r;
    r      = m ? longint'(d) * d * d : longint'(d) * d;
    e.err  = (r >= (longint'(1) << OB));
    e.dout = e.err ? '1 : OB'(r);
    e.cap  = cap;
    e.lat  = m ? 2 * DB : DB;
    return e;
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each new result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("ready_busy_exclusive", 32'(ready & busy), 32'd0);
      check("error_only_with_ready", 32'(error & ~ready), 32'd0);
      if (ready && !prev_ready) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("dout", 32'(dout), 32'(e.dout));
          check("error", 32'(error), 32'(e.err));
          check("latency", 32'(cyc - e.cap), 32'(e.lat));
        end
      end
    end
    prev_ready = ready;
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One operation from IDLE/DONE; inputs scrambled while busy, optional stray Start.
  task automatic run_op(input bit m, input int d, input bit stray);
    int cap, lat;
    mode  = m;
    din   = DB'(d);
    start = 1'b1;
    cap   = cyc + 1;
    lat   = m ? 2 * DB : DB;
    q.push_back(model(m, d, cap));
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < lat; k++) begin
      check("busy_during_op", 32'(busy), 32'd1);
      check("no_ready_during_op", 32'(ready), 32'd0);
      din  = DB'($urandom);
      mode = 1'($urandom);
      start = (stray && k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("ready_at_latency", 32'(ready), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_stays", 32'({ready, busy, error}), 32'd0);
    end

    // Directed cases including overflow boundaries and trivial operands.
    run_op(1'b0, 5, 1'b0);
    run_op(1'b0, 9, 1'b0);
    run_op(1'b1, 3, 1'b0);
    run_op(1'b1, 4, 1'b0);
    run_op(1'b0, 7, 1'b0);
    run_op(1'b0, 8, 1'b0);
    run_op(1'b0, 0, 1'b0);
    run_op(1'b1, 1, 1'b0);
    run_op(1'b1, 63, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("done_holds", 32'(ready), 32'd1);
    end

    // Start held high: back-to-back ops, Din change ignored while busy.
    mode  = 1'b0;
    din   = '0;
    start = 1'b1;
    c0    = cyc + 1;
    q.push_back(model(1'b0, 0, c0));
    repeat (2) @(negedge clk);
    din = DB'(1);
    wait_cyc(c0 + DB);
    check("b2b_first_ready", 32'(ready), 32'd1);
    q.push_back(model(1'b0, 1, c0 + DB + 1));
    @(negedge clk);
    check("b2b_ready_one_cycle", 32'(ready), 32'd0);
    check("b2b_busy_again", 32'(busy), 32'd1);
    start = 1'b0;
    wait_cyc(c0 + 2 * DB + 1);
    check("b2b_second_ready", 32'(ready), 32'd1);
    @(negedge clk);

    // Reset mid-operation: no result may appear afterwards.
    mode  = 1'b0;
    din   = DB'(7);
    start = 1'b1;
    c0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c0 + 2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_flags", 32'({ready, busy, error}), 32'd0);
    reset = 1'b0;
    repeat (15) begin
      @(negedge clk);
      check("midrst_stays_idle", 32'({ready, busy}), 32'd0);
    end

    // Randomized operations with random gaps and stray Start pulses.
    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
